instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the number of fetch-buffer entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit; reset rst, synchronous, active-high.
REQ-005 SHALL have port imem_addr, output, 32 bits, the byte address driven to the combinational instruction memory.
REQ-006 SHALL have port imem_rdata, input, 32 bits, the little-endian instruction word at imem_addr, valid in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1 bit, a branch/jump taken pulse from execute.
REQ-008 SHALL have port redirect_pc, input, 32 bits, the byte address of the redirect target.
REQ-009 SHALL have port id_ready, input, 1 bit; decode accepts the head entry, and low means hazard stall.
REQ-010 SHALL have port id_valid, output, 1 bit, asserted when id_instr/id_pc hold a valid entry.
REQ-011 SHALL have port id_instr, output, 32 bits, the instruction word at the buffer head.
REQ-012 SHALL have port id_pc, output, 32 bits, the byte address of id_instr.

Function
REQ-013 SHALL drive imem_addr = pc combinationally every cycle; pc[1:0] SHALL always be 2'b00.
REQ-014 SHALL push {pc, imem_rdata} into the buffer when push_en = !redirect_valid && (!full || pop).
REQ-015 SHALL advance pc <= pc + 4 on push_en, with modulo-2^32 wrap (32'hFFFF_FFFC -> 32'h0); otherwise SHALL hold pc.
REQ-016 SHALL define pop = id_valid && id_ready; id_valid = !empty; id_instr/id_pc = head entry, driven combinationally from registers.
REQ-017 SHALL have a minimum fetch-to-decode latency of 1 cycle: a word fetched in cycle N is presented no earlier than cycle N+1. There is no bypass.
REQ-018 On redirect_valid, SHALL flush all buffer entries, load pc <= {redirect_pc[31:2], 2'b00}, and suppress push and pop effects that cycle; id_valid SHALL be 0 the next cycle.
REQ-019 On simultaneous redirect_valid and pop, redirect SHALL win; the pop is counted as accepted by decode, but the buffer is empty afterwards.
REQ-020 When full with id_ready=0, SHALL hold pc, buffer contents and outputs stable (no drop, no duplicate).
REQ-021 When full with id_ready=1, SHALL pop the head and push the new word in the same cycle; occupancy stays unchanged.
REQ-022 Steady-state throughput with id_ready held 1 SHALL be one instruction per cycle, in ascending PC order.
REQ-023 Buffer pointers SHALL be log2(FIFO_DEPTH) bits plus a wrap bit; full/empty SHALL be derived from pointer comparison.

Reset
REQ-024 While rst=1 at a clock edge: pc <= RESET_PC, buffer emptied, id_valid=0.
REQ-025 id_instr and id_pc SHALL read 32'h0 while empty after reset.
REQ-026 rst SHALL take priority over redirect_valid and all handshakes; asserting it mid-stream SHALL discard every buffered entry.
REQ-027 Fetch SHALL resume at RESET_PC in the first cycle after rst deasserts.

Structure
REQ-028 SHALL import shared package cpu_pkg for XLEN=32, INSTR_BYTES=4, NOP_INSTR=32'h0 and the fetch_entry_t struct {pc, instr}.
REQ-029 The buffer SHALL be a separate sub-module fetch_fifo: a synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and head ports.
REQ-030 The PC register and push/redirect control SHALL reside in instr_fetch.

Verification
REQ-031 Reset release, id_ready=1, memory holding words W0..W3 at 0x0..0xC -> id_valid rises in cycle 1; id_pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles with matching words.
REQ-032 id_ready=0 for 5 cycles after 2 pushes -> full; imem_addr frozen at 0x8; outputs hold id_pc=0x0; on release, 0x0, 0x4, 0x8 follow with no gap or duplicate.
REQ-033 redirect_valid with redirect_pc=0x9E in the same cycle as pop -> next cycle id_valid=0, imem_addr=0x9C; the following cycle id_pc=0x9C.
REQ-034 RESET_PC=32'hFFFF_FFF8, id_ready=1 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 rst asserted with 2 entries buffered and a redirect pending -> next cycle id_valid=0 and imem_addr=RESET_PC; redirect ignored.
REQ-036 Random id_ready with a scoreboard -> every fetched PC is delivered exactly once and in order between redirects.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   XLEN          : datapath / address width
//   INSTR_BYTES   : size of one instruction word in bytes
//   NOP_INSTR     : word presented on the decode interface while no entry is held
//   fetch_entry_t : one fetch-buffer entry, {pc, instr}
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries sitting between fetch and decode.
//   clk, rst    : rising-edge clock, synchronous active-high reset (empties FIFO)
//   push_i      : write push_data_i at the tail (accepted when not full, or full with pop)
//   push_data_i : entry to write
//   pop_i       : drop the head entry (ignored when empty)
//   flush_i     : discard every entry; overrides push and pop this cycle
//   full_o      : all DEPTH entries occupied
//   empty_o     : no entries held
//   head_o      : head entry, {0, NOP_INSTR} while empty
// Pointers carry one extra wrap bit so full and empty come straight from a
// pointer compare, with no separate occupancy counter.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o && !flush_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is never observed while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  always_comb begin
    if (empty_o) begin
      head_o.pc    = '0;
      head_o.instr = NOP_INSTR;
    end else begin
      head_o = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction
// memory and queues {pc, instr} entries for decode.
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   imem_addr      : word-aligned fetch address (= pc)
//   imem_rdata     : instruction word at imem_addr, same cycle
//   redirect_valid : taken branch/jump pulse; flushes the buffer
//   redirect_pc    : redirect target (low two bits ignored)
//   id_ready       : decode accepts the head entry (low = stall)
//   id_valid       : id_instr/id_pc hold a valid entry
//   id_instr/id_pc : head entry of the fetch buffer
// Handshake: an entry transfers on a cycle where id_valid && id_ready at the
// rising edge; id_valid never depends on id_ready, and the entry stays
// stable until it transfers or a redirect/reset discards it.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            push_en;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic [1:0]      unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  assign imem_addr = pc_q;
  assign id_valid  = !fifo_empty;
  assign id_instr  = head.instr;
  assign id_pc     = head.pc;

  assign pop     = id_valid && id_ready;
  assign push_en = !redirect_valid && (!fifo_full || pop);

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_rdata;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push_en) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);  // wraps modulo 2^32
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= {RESET_PC[31:2], 2'b00};
    else     pc_q <= pc_d;
  end

  // A redirect still counts as a decode acceptance, but the flush makes the
  // FIFO ignore both push and pop, leaving it empty.
  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_en),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. Reset PC sits just below the 2^32
// boundary so every reset exercises address wrap. The reference model is a
// queue of fetched entries plus a fetch pointer, updated from the stage's
// rules each clock; the monitor compares the decode interface against the
// queue head each cycle and retires entries on accepted handshakes.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 2;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int checks;
  int passes;

  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  bit          model_ok;

  instr_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // ---------------- reference model ----------------
  // Inputs change only on the falling edge, so they are stable here.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_pc = RST_PC;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else if (exp_q.size() < DEPTH) begin
        // The monitor has already retired an accepted head this cycle,
        // so spare room here covers both "not full" and "full with pop".
        exp_q.push_back({model_pc, mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    #1;
    if (model_ok) begin
      check("imem_addr", imem_addr, model_pc);
      check("id_valid", {31'b0, id_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("id_pc", id_pc, exp_q[0][63:32]);
        check("id_instr", id_instr, exp_q[0][31:0]);
        if (id_ready) void'(exp_q.pop_front());
      end else begin
        check("id_pc_empty", id_pc, 32'h0);
        check("id_instr_empty", id_instr, 32'h0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
  endtask

  initial begin
    model_ok       = 1'b0;
    model_pc       = '0;
    checks         = 0;
    passes         = 0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;

    // Reset, then stream across the 2^32 wrap.
    repeat (3) drive(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect to address 0 and stream 0x0, 0x4, 0x8, ...
    drive(1'b0, 1'b1, 32'h0, 1'b1);
    repeat (5) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Stall long enough to fill the buffer, then release.
    drive(1'b0, 1'b1, 32'h0, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect to an unaligned target while decode is accepting.
    drive(1'b0, 1'b1, 32'h0000_009E, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Fill the buffer, then reset with a redirect pending.
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0500, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic: stalls, redirects (some near the wrap), resets.
    for (int i = 0; i < 3000; i++) begin
      logic        r, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 149) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | {28'b0, rpc[3:0]};
      drive(r, rv, rpc, rdy);
    end

    repeat (4) drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
